multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Multi-channel, prescaled compare timer; generalises the single free-running period counter to NUM_CH independent channels.
- Each channel has its own compare value, one-shot/periodic mode, pause/resume, a sticky interrupt flag and an overrun flag.
- All channels share one programmable prescaler tick.
- Sits next to the core as the event and interrupt timing source.

Parameters:
- NUM_CH, 4: number of independent timer channels (1..16).
- CNT_WIDTH, 32: width of each channel counter and compare value.
- PRESC_WIDTH, 8: width of the shared prescaler divider.
- CH_IDX_W, $clog2(NUM_CH) (min 1): width of the channel select field.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- presc_div_i  in  PRESC_WIDTH  tick every presc_div_i+1 clk cycles
- cfg_we_i  in  1  write config to channel cfg_ch_i
- cfg_ch_i  in  CH_IDX_W  target channel for config write
- cfg_cmp_i  in  CNT_WIDTH  compare value to load
- cfg_periodic_i  in  1  1 = periodic mode, 0 = one-shot mode
- start_i  in  NUM_CH  per-channel start/resume pulse
- stop_i  in  NUM_CH  per-channel pause pulse
- irq_ack_i  in  NUM_CH  per-channel clear of irq_o and missed_o
- cnt_o  out  NUM_CH*CNT_WIDTH  channel counters, ch0 in LSBs
- busy_o  out  NUM_CH  channel in RUN
- irq_o  out  NUM_CH  sticky match flag
- missed_o  out  NUM_CH  match occurred while irq_o was already pending

Behaviour:
- Reset (async): all counters, compare values, modes, prescaler count, irq_o, missed_o and busy_o = 0; all channels IDLE.
- Prescaler:
  - Free-running presc_cnt.
  - tick = (presc_cnt >= presc_div_i). On tick presc_cnt <= 0, otherwise presc_cnt+1.
  - presc_div_i = 0 gives a tick every cycle.
  - Lowering presc_div_i below presc_cnt yields a tick on the next cycle, with no long wrap.
- Per-channel FSM with states IDLE, RUN, DONE (encoded 2 bits). busy_o = (state == RUN).
- Command priority per channel per cycle: cfg write > stop > start. Only the channel addressed by cfg_ch_i is affected by cfg_we_i; a cfg_ch_i >= NUM_CH write is ignored.
- cfg write: load cmp and mode, cnt <= 0, state <= IDLE. irq_o and missed_o are unchanged.
- stop:
  - RUN -> IDLE; cnt held.
  - Ignored in IDLE and DONE.
- start:
  - IDLE -> RUN, resuming from the held cnt.
  - DONE -> RUN with cnt <= 0.
  - Ignored in RUN.
  - A command takes effect at the next clk edge; the tick in the same cycle does not advance a channel that was not already in RUN.
- RUN on tick:
  - If cnt == cmp it is a match.
    - Periodic: cnt <= 0, stay RUN. Period = (cmp+1) ticks; cmp = 0 matches every tick.
    - One-shot: cnt holds at cmp, state <= DONE.
  - Otherwise cnt <= cnt+1, wrapping modulo 2^CNT_WIDTH. Wrap is reachable only if cmp changed, which cannot happen in RUN, so effectively unreachable.
- RUN without tick: no change.
- Match flags:
  - irq_o <= 1 on match.
  - If irq_o is already 1 and irq_ack_i is not asserted that cycle, missed_o <= 1.
  - irq_ack_i clears irq_o and missed_o. If a match and an ack occur in the same cycle, irq_o = 1 and missed_o = 0 (set wins for irq, ack wins for missed).
- Outputs are registered. irq_o rises one clk after the tick cycle in which cnt == cmp.
- A channel that is not started never asserts irq_o.

Test Plan:
- Reset mid-run: ch0 RUN at cnt = 5, assert rst_n = 0 -> all outputs 0 immediately (async), IDLE after release.
- presc_div_i = 3, ch1 periodic cmp = 2, start -> irq_o[1] first rises 12 clk after start (3 ticks x 4 clk). After ack it re-rises every 12 clk. cnt_o sequence is 0,1,2,0.
- ch2 one-shot cmp = 4, presc_div_i = 0, start -> irq_o[2] after 5 ticks, busy_o[2] = 0, cnt = 4 held. A second start restarts from 0.
- Pause/resume: ch0 periodic cmp = 100, stop at cnt = 37, wait 50 clk -> cnt stays 37. Start -> continues 38, 39, ...
- Overrun and simultaneous events: ch3 periodic cmp = 0, presc_div_i = 0, no ack -> irq_o = 1 on first tick, missed_o = 1 on second. Ack coinciding with a match -> irq_o = 1, missed_o = 0.
- Priority: same cycle cfg_we (ch0, cmp = 9), stop[0], start[0] while ch0 RUN -> ch0 IDLE, cnt = 0, cmp = 9. stop+start with no cfg on a RUN channel -> IDLE. Write to cfg_ch = 5 with NUM_CH = 4 -> no channel changes.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent compare timers sharing one programmable prescaler tick.
// Each channel runs an IDLE/RUN/DONE FSM in one-shot or periodic mode with sticky irq and overrun flags.
module multi_timer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8,
  parameter int CH_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PRESC_WIDTH-1:0]        presc_div_i,
  input  logic                          cfg_we_i,
  input  logic [CH_IDX_W-1:0]           cfg_ch_i,
  input  logic [CNT_WIDTH-1:0]          cfg_cmp_i,
  input  logic                          cfg_periodic_i,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             stop_i,
  input  logic [NUM_CH-1:0]             irq_ack_i,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_o,
  output logic [NUM_CH-1:0]             busy_o,
  output logic [NUM_CH-1:0]             irq_o,
  output logic [NUM_CH-1:0]             missed_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [PRESC_WIDTH-1:0] presc_cnt_r;
  logic                   tick_s;

  // Using >= means a divider lowered below the current count ticks at once instead of wrapping.
  assign tick_s = (presc_cnt_r >= presc_div_i);

  // Shared free-running prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_r <= {PRESC_WIDTH{1'b0}};
    end else if (tick_s) begin
      presc_cnt_r <= {PRESC_WIDTH{1'b0}};
    end else begin
      presc_cnt_r <= presc_cnt_r + PRESC_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e                 state_r, state_n;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_n, cmp_r, cmp_n;
    logic                   per_r, per_n;
    logic                   busy_r, irq_r, irq_n, missed_r, missed_n;
    logic                   cfg_hit_s, match_s;

    // Out-of-range channel indices never match any g, so such writes fall on the floor.
    assign cfg_hit_s = cfg_we_i && (cfg_ch_i == CH_IDX_W'(g));

    // Channel next state: cfg write beats an effective stop, which beats an effective start, then counting.
    always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      cmp_n   = cmp_r;
      per_n   = per_r;
      match_s = 1'b0;
      if (cfg_hit_s) begin
        cmp_n   = cfg_cmp_i;
        per_n   = cfg_periodic_i;
        cnt_n   = {CNT_WIDTH{1'b0}};
        state_n = ST_IDLE;
      end else if (stop_i[g] && (state_r == ST_RUN)) begin
        state_n = ST_IDLE;
      end else if (start_i[g] && (state_r != ST_RUN)) begin
        case (state_r)
          ST_IDLE: state_n = ST_RUN;
          ST_DONE: begin
            state_n = ST_RUN;
            cnt_n   = {CNT_WIDTH{1'b0}};
          end
          default: state_n = ST_IDLE;
        endcase
      end else if (tick_s && (state_r == ST_RUN)) begin
        if (cnt_r == cmp_r) begin
          match_s = 1'b1;
          if (per_r) begin
            cnt_n = {CNT_WIDTH{1'b0}};
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          cnt_n = cnt_r + CNT_WIDTH'(1);
        end
      end else begin
        state_n = state_r;
      end
    end

    // Match sets irq; ack wins for missed but loses to a simultaneous match for irq.
    always_comb begin
      irq_n    = irq_r;
      missed_n = missed_r;
      if (match_s) begin
        irq_n = 1'b1;
        if (irq_r && !irq_ack_i[g]) begin
          missed_n = 1'b1;
        end else if (irq_ack_i[g]) begin
          missed_n = 1'b0;
        end else begin
          missed_n = missed_r;
        end
      end else if (irq_ack_i[g]) begin
        irq_n    = 1'b0;
        missed_n = 1'b0;
      end else begin
        irq_n    = irq_r;
        missed_n = missed_r;
      end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r  <= ST_IDLE;
        cnt_r    <= {CNT_WIDTH{1'b0}};
        cmp_r    <= {CNT_WIDTH{1'b0}};
        per_r    <= 1'b0;
        busy_r   <= 1'b0;
        irq_r    <= 1'b0;
        missed_r <= 1'b0;
      end else begin
        state_r  <= state_n;
        cnt_r    <= cnt_n;
        cmp_r    <= cmp_n;
        per_r    <= per_n;
        busy_r   <= (state_n == ST_RUN);
        irq_r    <= irq_n;
        missed_r <= missed_n;
      end
    end

    assign cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
    assign busy_o[g]   = busy_r;
    assign irq_o[g]    = irq_r;
    assign missed_o[g] = missed_r;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a table of per-cycle vectors checked through a scoreboard
// queue, followed by hand-written sequences for prescaler timing, pause/resume, priority and reset.
module tb_multi_timer;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 8;
  localparam int IW  = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [PW-1:0]       presc_div = 8'd0;
  logic                cfg_we = 1'b0;
  logic [IW-1:0]       cfg_ch = 3'd0;
  logic [CW-1:0]       cfg_cmp = 32'd0;
  logic                cfg_periodic = 1'b0;
  logic [NCH-1:0]      start = 4'd0;
  logic [NCH-1:0]      stop = 4'd0;
  logic [NCH-1:0]      irq_ack = 4'd0;
  logic [NCH*CW-1:0]   cnt;
  logic [NCH-1:0]      busy, irq, missed;

  int n_vec  = 0;
  int n_miss = 0;

  multi_timer #(.NUM_CH(NCH), .CNT_WIDTH(CW), .PRESC_WIDTH(PW), .CH_IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .presc_div_i(presc_div),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_cmp_i(cfg_cmp), .cfg_periodic_i(cfg_periodic),
    .start_i(start), .stop_i(stop), .irq_ack_i(irq_ack),
    .cnt_o(cnt), .busy_o(busy), .irq_o(irq), .missed_o(missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  ch;
    logic [31:0] cmp;
    logic        per;
    logic [3:0]  st, sp, ak;
    logic [31:0] c2, c3;
    logic [3:0]  b, i, m;
  } vec_t;

  typedef struct {
    logic [127:0] cnt;
    logic [3:0]   b, i, m;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return cnt[ch*CW +: CW];
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] ch, input logic [31:0] cmp,
                              input logic per, input logic [3:0] st, input logic [3:0] sp,
                              input logic [3:0] ak, input logic [31:0] c2, input logic [31:0] c3,
                              input logic [3:0] b, input logic [3:0] i, input logic [3:0] m);
    vec_t v;
    v.we = we; v.ch = ch; v.cmp = cmp; v.per = per; v.st = st; v.sp = sp; v.ak = ak;
    v.c2 = c2; v.c3 = c3; v.b = b; v.i = i; v.m = m;
    return v;
  endfunction

  // One clock: drive inputs, let the edge take them, sample 1 time unit later, return to idle.
  task automatic drive(input logic we, input logic [2:0] ch, input logic [31:0] cmp, input logic per,
                       input logic [3:0] st, input logic [3:0] sp, input logic [3:0] ak);
    cfg_we = we; cfg_ch = ch; cfg_cmp = cmp; cfg_periodic = per;
    start = st; stop = sp; irq_ack = ak;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; start = 4'd0; stop = 4'd0; irq_ack = 4'd0;
  endtask

  task automatic cyc(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] ak);
    drive(1'b0, 3'd0, 32'd0, 1'b0, st, sp, ak);
  endtask

  initial begin
    int first_k, rise2_k;
    logic [31:0] c_at4, c_at8, c_at12;
    logic        irq_after_ack;
    exp_t e;

    // One-shot ch2 (cmp 4) and periodic ch3 (cmp 0), tick every cycle.
    vecs.push_back(mk(1'b1, 3'd2, 32'd4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b1, 3'd3, 32'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 32'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 32'd0, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd2, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd3, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd4, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd4, 32'd0, 4'b0000, 4'b0100, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd4, 32'd0, 4'b0000, 4'b0100, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 32'd0, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 32'd1, 32'd0, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b1000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b1000, 4'b1000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b1000, 4'b1000, 4'b1000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b1000, 32'd1, 32'd0, 4'b1000, 4'b1000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b1000, 4'b1000, 4'b1000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 32'd1, 32'd0, 4'b0000, 4'b1000, 4'b1000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b1000, 32'd1, 32'd0, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 32'd1, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'd2, 32'd0, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1'b0, 3'd0, 32'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 32'd2, 32'd0, 4'b0000, 4'b0000, 4'b0000));

    #12;
    chk("reset_cnt", cnt, 128'd0);
    chk("reset_flags", {busy, irq, missed}, 128'd0);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      e.cnt = {vecs[n].c3, vecs[n].c2, 64'd0};
      e.b = vecs[n].b; e.i = vecs[n].i; e.m = vecs[n].m;
      exp_q.push_back(e);
      drive(vecs[n].we, vecs[n].ch, vecs[n].cmp, vecs[n].per, vecs[n].st, vecs[n].sp, vecs[n].ak);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_cnt", n), cnt, e.cnt);
      chk($sformatf("vec%0d_busy", n), {124'd0, busy}, {124'd0, e.b});
      chk($sformatf("vec%0d_irq", n), {124'd0, irq}, {124'd0, e.i});
      chk($sformatf("vec%0d_missed", n), {124'd0, missed}, {124'd0, e.m});
    end

    // Prescaler: ch1 periodic cmp 2, divider 3 armed so a tick lands on the start cycle.
    drive(1'b1, 3'd1, 32'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    presc_div = 8'd3;
    cyc(4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0010, 4'b0000, 4'b0000);
    chk("presc_start_cnt", {96'd0, cnt_of(1)}, 128'd0);
    first_k = 0; rise2_k = 0; c_at4 = 32'hFFFF_FFFF; c_at8 = 32'hFFFF_FFFF; c_at12 = 32'hFFFF_FFFF;
    irq_after_ack = 1'b1;
    for (int k = 1; k <= 40 && rise2_k == 0; k++) begin
      cyc(4'b0000, 4'b0000, (k == 13) ? 4'b0010 : 4'b0000);
      if (k == 4) c_at4 = cnt_of(1);
      if (k == 8) c_at8 = cnt_of(1);
      if (k == 12) c_at12 = cnt_of(1);
      if (k == 13) irq_after_ack = irq[1];
      if (irq[1] && first_k == 0) first_k = k;
      else if (irq[1] && k > 13 && rise2_k == 0) rise2_k = k;
    end
    chk("presc_first_irq", 128'(first_k), 128'd12);
    chk("presc_cnt_seq", {32'd0, c_at4, c_at8, c_at12}, {32'd0, 32'd1, 32'd2, 32'd0});
    chk("presc_ack_clear", {127'd0, irq_after_ack}, 128'd0);
    chk("presc_period", 128'(rise2_k - first_k), 128'd12);
    presc_div = 8'd0;
    cyc(4'b0000, 4'b0010, 4'b0010);

    // Pause/resume ch0 periodic cmp 100.
    drive(1'b1, 3'd0, 32'd100, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0001, 4'b0000, 4'b0000);
    repeat (37) cyc(4'b0000, 4'b0000, 4'b0000);
    chk("pause_pre", {96'd0, cnt_of(0)}, 128'd37);
    cyc(4'b0000, 4'b0001, 4'b0000);
    repeat (50) cyc(4'b0000, 4'b0000, 4'b0000);
    chk("pause_hold", {95'd0, busy[0], cnt_of(0)}, 128'd37);
    cyc(4'b0001, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000);
    chk("resume_38", {95'd0, busy[0], cnt_of(0)}, {95'd0, 1'b1, 32'd38});
    cyc(4'b0000, 4'b0000, 4'b0000);
    chk("resume_39", {96'd0, cnt_of(0)}, 128'd39);

    // Priority: cfg + stop + start on running ch0 leaves it IDLE at 0 with cmp 9 one-shot.
    drive(1'b1, 3'd0, 32'd9, 1'b0, 4'b0001, 4'b0001, 4'b0000);
    chk("prio_cfg", {95'd0, busy[0], cnt_of(0)}, 128'd0);
    cyc(4'b0001, 4'b0000, 4'b0000);
    repeat (9) cyc(4'b0000, 4'b0000, 4'b0000);
    chk("prio_cmp9_pre", {95'd0, irq[0], cnt_of(0)}, 128'd9);
    cyc(4'b0000, 4'b0000, 4'b0000);
    chk("prio_cmp9_match", {94'd0, irq[0], busy[0], cnt_of(0)}, {94'd0, 1'b1, 1'b0, 32'd9});
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("restart_done", {95'd0, busy[0], cnt_of(0)}, {95'd0, 1'b1, 32'd0});
    cyc(4'b0001, 4'b0001, 4'b0000);
    chk("stop_start_run", {127'd0, busy[0]}, 128'd0);

    // Out-of-range channel writes must not disturb running channels.
    cyc(4'b0011, 4'b0000, 4'b0000);
    drive(1'b1, 3'd5, 32'd7, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("oob5", {94'd0, busy[1:0], cnt_of(0)}, {94'd0, 2'b11, 32'd1});
    drive(1'b1, 3'd4, 32'd7, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    chk("oob4", {94'd0, busy[1:0], cnt_of(0)}, {94'd0, 2'b11, 32'd2});

    // Reset mid-run: ch0 running at 5, outputs clear without a clock edge.
    repeat (3) cyc(4'b0000, 4'b0000, 4'b0000);
    chk("mid_cnt5", {96'd0, cnt_of(0)}, 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt, 128'd0);
    chk("async_rst_flags", {busy, irq, missed}, 128'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(4'b0000, 4'b0000, 4'b0000);
    chk("post_rst_idle", {busy, cnt_of(0)}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
